urv_dbg_mailbox: RTL and testbench
==================================

# urv_dbg_mailbox

Parametrised bidirectional debug mailbox for the uRV core, replacing the single-entry mailbox registers in the CSR unit. Two independent synchronous FIFOs carry words between the core (CSR side) and the external debugger (debug side): MBXO from core to debugger and MBXI from debugger to core. A status word exposes fill levels and sticky overflow flags. The CSR unit decodes the DBGMBXI/DBGMBXO/DBGSTATUS selectors and drives this block with already-committed strobes.

## Interface
Parameters:
- DEPTH_LOG2, default 2: log2 of the entry count per FIFO (range 0..7); DEPTH = 2**DEPTH_LOG2.
- WIDTH, default 32: data word width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, asynchronous, active-high
- csr_mbxo_push_i  in  1  committed CSR write to DBGMBXO; gated upstream by !stall, !kill and is_csr
- csr_mbxo_data_i  in  WIDTH  CSR write value
- csr_mbxi_pop_i  in  1  committed CSR write to DBGMBXI; pops the MBXI head
- csr_mbxi_data_o  out  WIDTH  MBXI head word (first-word-fall-through)
- csr_status_we_i  in  1  committed CSR write to DBGSTATUS
- csr_status_wdata_i  in  32  DBGSTATUS write value; bits 4 and 5 are write-1-to-clear
- csr_status_o  out  32  DBGSTATUS read value
- dbg_mbxi_write_i  in  1  debugger push into MBXI
- dbg_mbxi_data_i  in  WIDTH  debugger push data
- dbg_mbxi_full_o  out  1  MBXI holds DEPTH entries
- dbg_mbxo_read_i  in  1  debugger pop from MBXO
- dbg_mbxo_data_o  out  WIDTH  MBXO head word (first-word-fall-through)
- dbg_mbxo_full_o  out  1  MBXO is non-empty (data available to the debugger)

## Operation
- Each FIFO is a DEPTH×WIDTH register array with read pointer, write pointer and count. The pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH. The count is DEPTH_LOG2+1 bits wide.
- Push into a full FIFO: data and pointers are unchanged.
- Pop from an empty FIFO: ignored; nothing changes.
- Simultaneous push and pop:
  - Non-empty and not full: both take effect and count is unchanged.
  - Full: both take effect; the pop frees the slot. This is not an overflow.
  - Empty: the push takes effect and the pop is ignored; count becomes 1.
- Head data when the FIFO is empty: drive the entry at the read pointer. The value is don't-care and is not checked.
- csr_status_o fields:
  - [0] MBXI non-empty
  - [1] MBXO non-empty
  - [2] MBXI full
  - [3] MBXO full
  - [4] MBXI overflow
  - [5] MBXO overflow
  - [6:7] zero
  - [15:8] MBXI count, zero-extended
  - [23:16] MBXO count, zero-extended
  - [31:24] zero
- Bits [1:0] match the legacy DBGSTATUS layout, so depth-agnostic software keeps working.
- With DEPTH_LOG2=0 the block behaves exactly like the legacy single-entry mailbox, except that a push into a full FIFO is dropped instead of overwriting.
- Reset values: all pointers, counts and sticky flags 0; storage 0. Therefore csr_status_o=0, dbg_mbxi_full_o=0, dbg_mbxo_full_o=0, csr_mbxi_data_o=0, dbg_mbxo_data_o=0.

## Timing
- All state updates on the rising edge of clk_i.
- Reset acts immediately on assertion. It aborts any in-flight push or pop and discards FIFO contents.
- Push-to-visible latency: 1 cycle. Data pushed at edge N appears at the head and in the count/flags after edge N.
- Pop: the next head word is visible in the cycle after the popping edge.
- All outputs are registered-state-derived combinational decodes. There is no input-to-output combinational path.
- Overflow flag set and W1C clear in the same cycle: the set wins.

## Configuration
- URV_DBG_MBX_OVF_EN defined:
  - Status bits [5:4] are sticky overflow flags.
  - A flag is set on a push into a full FIFO that has no simultaneous pop.
  - A flag is cleared by a csr_status_we_i write with the corresponding bit set to 1.
- URV_DBG_MBX_OVF_EN undefined:
  - No flag registers are instantiated.
  - Bits [5:4] read 0.
  - Writes to DBGSTATUS have no effect.
  - Dropped pushes are silent.

## Structure
- Shared defines (urv_defs.v): DBGSTATUS bit positions and field offsets (MBXI_NE=0, MBXO_NE=1, MBXI_FULL=2, MBXO_FULL=3, MBXI_OVF=4, MBXO_OVF=5, MBXI_CNT=8, MBXO_CNT=16).
- One sub-module, urv_dbg_fifo:
  - Parameters: DEPTH_LOG2, WIDTH.
  - Ports: push, pop, data in, head out, count, empty, full, overflow pulse.
  - Instantiated twice, once for MBXI and once for MBXO.
- The top level holds only the sticky flags and the status word assembly.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 via csr_mbxo_push_i with DEPTH_LOG2=2 → status[23:16]=3, dbg_mbxo_data_o=0x11. Three dbg_mbxo_read_i pops return 0x11, 0x22, 0x33, then dbg_mbxo_full_o=0.
- Five debugger pushes 0xA0..0xA4 into MBXI with DEPTH=4 → dbg_mbxi_full_o=1 after the fourth; 0xA4 is dropped; status[4]=1 with OVF_EN; four pops return 0xA0..0xA3.
- MBXI full, then dbg_mbxi_write_i and csr_mbxi_pop_i in the same cycle → count stays 4, no overflow flag, 0xA4 becomes the last entry.
- Status write 0x10 while an overflow push occurs in the same cycle → status[4] stays 1. A write of 0x10 in the next cycle → status[4]=0.
- More than 2·DEPTH push/pop pairs to exercise pointer wrap → data order preserved, and the count never exceeds DEPTH.
- rst_i asserted mid-stream with MBXO holding 2 entries → immediately status=0 and dbg_mbxo_full_o=0; after release, a push of 0x55 reads back 0x55.

Source files
------------

// File: rtl/urv_dbg_mailbox_pkg.sv
// Shared DBGSTATUS layout for the uRV debug mailbox: bit positions, field offsets
// and a packed view of the status word.
package urv_dbg_mailbox_pkg;

    localparam int MBXI_NE   = 0;
    localparam int MBXO_NE   = 1;
    localparam int MBXI_FULL = 2;
    localparam int MBXO_FULL = 3;
    localparam int MBXI_OVF  = 4;
    localparam int MBXO_OVF  = 5;
    localparam int MBXI_CNT  = 8;
    localparam int MBXO_CNT  = 16;

    localparam int STATUS_W  = 32;
    localparam int CNT_W     = 8;

    // Field order mirrors the offsets above, MSB first.
    typedef struct packed {
        logic [7:0]       reserved_hi;
        logic [CNT_W-1:0] mbxo_cnt;
        logic [CNT_W-1:0] mbxi_cnt;
        logic [1:0]       reserved_lo;
        logic             mbxo_ovf;
        logic             mbxi_ovf;
        logic             mbxo_full;
        logic             mbxi_full;
        logic             mbxo_ne;
        logic             mbxi_ne;
    } dbg_status_t;

endpackage

// File: rtl/urv_dbg_fifo.sv
// Synchronous first-word-fall-through FIFO used for both mailbox directions.
// Pushes into a full FIFO are dropped and reported on the overflow pulse.
module urv_dbg_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      data,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push && (!full || pop);
    assign overflow = push && full && !pop;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/urv_dbg_mailbox.sv
// Bidirectional core/debugger mailbox: MBXO (core->debugger), MBXI (debugger->core).
// Sticky overflow flags exist only when URV_DBG_MBX_OVF_EN is defined.
module urv_dbg_mailbox
    import urv_dbg_mailbox_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  csr_mbxo_push_i,
    input  logic [WIDTH-1:0]      csr_mbxo_data_i,
    input  logic                  csr_mbxi_pop_i,
    output logic [WIDTH-1:0]      csr_mbxi_data_o,
    input  logic                  csr_status_we_i,
    input  logic [STATUS_W-1:0]   csr_status_wdata_i,
    output logic [STATUS_W-1:0]   csr_status_o,
    input  logic                  dbg_mbxi_write_i,
    input  logic [WIDTH-1:0]      dbg_mbxi_data_i,
    output logic                  dbg_mbxi_full_o,
    input  logic                  dbg_mbxo_read_i,
    output logic [WIDTH-1:0]      dbg_mbxo_data_o,
    output logic                  dbg_mbxo_full_o
);

    logic [DEPTH_LOG2:0] mbxi_count;
    logic [DEPTH_LOG2:0] mbxo_count;
    logic                mbxi_empty;
    logic                mbxo_empty;
    logic                mbxi_full;
    logic                mbxo_full;
    logic                mbxi_ovf_pulse;
    logic                mbxo_ovf_pulse;
    logic                mbxi_ovf;
    logic                mbxo_ovf;
    logic                unused_status;
    dbg_status_t         status;

    urv_dbg_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_mbxi (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (dbg_mbxi_write_i),
        .pop      (csr_mbxi_pop_i),
        .data     (dbg_mbxi_data_i),
        .head     (csr_mbxi_data_o),
        .count    (mbxi_count),
        .empty    (mbxi_empty),
        .full     (mbxi_full),
        .overflow (mbxi_ovf_pulse)
    );

    urv_dbg_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_mbxo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (csr_mbxo_push_i),
        .pop      (dbg_mbxo_read_i),
        .data     (csr_mbxo_data_i),
        .head     (dbg_mbxo_data_o),
        .count    (mbxo_count),
        .empty    (mbxo_empty),
        .full     (mbxo_full),
        .overflow (mbxo_ovf_pulse)
    );

`ifdef URV_DBG_MBX_OVF_EN
    // A new overflow in the same cycle as a W1C clear keeps the flag set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mbxi_ovf <= 1'b0;
            mbxo_ovf <= 1'b0;
        end else begin
            mbxi_ovf <= mbxi_ovf_pulse ||
                        (mbxi_ovf && !(csr_status_we_i && csr_status_wdata_i[MBXI_OVF]));
            mbxo_ovf <= mbxo_ovf_pulse ||
                        (mbxo_ovf && !(csr_status_we_i && csr_status_wdata_i[MBXO_OVF]));
        end
    end

    assign unused_status = ^{csr_status_wdata_i[31:6], csr_status_wdata_i[3:0]};
`else
    assign mbxi_ovf      = 1'b0;
    assign mbxo_ovf      = 1'b0;
    assign unused_status = ^{csr_status_we_i, csr_status_wdata_i,
                             mbxi_ovf_pulse, mbxo_ovf_pulse};
`endif

    always_comb begin
        status             = '0;
        status.mbxi_ne     = !mbxi_empty;
        status.mbxo_ne     = !mbxo_empty;
        status.mbxi_full   = mbxi_full;
        status.mbxo_full   = mbxo_full;
        status.mbxi_ovf    = mbxi_ovf;
        status.mbxo_ovf    = mbxo_ovf;
        status.mbxi_cnt    = CNT_W'(mbxi_count);
        status.mbxo_cnt    = CNT_W'(mbxo_count);
    end

    assign csr_status_o    = status;
    assign dbg_mbxi_full_o = mbxi_full;
    assign dbg_mbxo_full_o = !mbxo_empty;

endmodule

// File: tb/tb_urv_dbg_mailbox.sv
// Scoreboard bench for urv_dbg_mailbox: queue-based reference model, directed
// sequences plus random traffic; honours URV_DBG_MBX_OVF_EN when defined.
module tb_urv_dbg_mailbox;

    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int WIDTH      = 32;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             csr_mbxo_push_i = 1'b0;
    logic [WIDTH-1:0] csr_mbxo_data_i = '0;
    logic             csr_mbxi_pop_i = 1'b0;
    logic [WIDTH-1:0] csr_mbxi_data_o;
    logic             csr_status_we_i = 1'b0;
    logic [31:0]      csr_status_wdata_i = '0;
    logic [31:0]      csr_status_o;
    logic             dbg_mbxi_write_i = 1'b0;
    logic [WIDTH-1:0] dbg_mbxi_data_i = '0;
    logic             dbg_mbxi_full_o;
    logic             dbg_mbxo_read_i = 1'b0;
    logic [WIDTH-1:0] dbg_mbxo_data_o;
    logic             dbg_mbxo_full_o;

    int tests_run = 0;
    int tests_failed = 0;

    logic [WIDTH-1:0] mi_q[$];
    logic [WIDTH-1:0] mo_q[$];
    logic             ovf_i = 1'b0;
    logic             ovf_o = 1'b0;

    logic [WIDTH-1:0] exp_mbxi_q[$];
    logic [WIDTH-1:0] exp_mbxo_q[$];
    logic [31:0]      exp_status = '0;
    logic             mon_en = 1'b0;

    urv_dbg_mailbox #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .csr_mbxo_push_i    (csr_mbxo_push_i),
        .csr_mbxo_data_i    (csr_mbxo_data_i),
        .csr_mbxi_pop_i     (csr_mbxi_pop_i),
        .csr_mbxi_data_o    (csr_mbxi_data_o),
        .csr_status_we_i    (csr_status_we_i),
        .csr_status_wdata_i (csr_status_wdata_i),
        .csr_status_o       (csr_status_o),
        .dbg_mbxi_write_i   (dbg_mbxi_write_i),
        .dbg_mbxi_data_i    (dbg_mbxi_data_i),
        .dbg_mbxi_full_o    (dbg_mbxi_full_o),
        .dbg_mbxo_read_i    (dbg_mbxo_read_i),
        .dbg_mbxo_data_o    (dbg_mbxo_data_o),
        .dbg_mbxo_full_o    (dbg_mbxo_full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelStatus();
        logic [31:0] s;
        s        = '0;
        s[0]     = (mi_q.size() != 0);
        s[1]     = (mo_q.size() != 0);
        s[2]     = (mi_q.size() == DEPTH);
        s[3]     = (mo_q.size() == DEPTH);
        s[4]     = ovf_i;
        s[5]     = ovf_o;
        s[15:8]  = 8'(mi_q.size());
        s[23:16] = 8'(mo_q.size());
        return s;
    endfunction

    // Drives one clock worth of inputs and advances the reference model past that edge.
    task automatic applyStimulus(input logic o_push, input logic [WIDTH-1:0] o_data,
                                 input logic o_rd, input logic i_wr,
                                 input logic [WIDTH-1:0] i_data, input logic i_pop,
                                 input logic s_we, input logic [31:0] s_wdata);
        logic o_full, i_full, o_ovf, i_ovf;
        @(posedge clk_i);
        #1;
        exp_status         = modelStatus();
        mon_en             = 1'b1;
        csr_mbxo_push_i    = o_push;
        csr_mbxo_data_i    = o_data;
        dbg_mbxo_read_i    = o_rd;
        dbg_mbxi_write_i   = i_wr;
        dbg_mbxi_data_i    = i_data;
        csr_mbxi_pop_i     = i_pop;
        csr_status_we_i    = s_we;
        csr_status_wdata_i = s_wdata;

        o_full = (mo_q.size() == DEPTH);
        i_full = (mi_q.size() == DEPTH);
        o_ovf  = o_push && o_full && !o_rd;
        i_ovf  = i_wr && i_full && !i_pop;

        if (o_rd && mo_q.size() != 0) begin
            exp_mbxo_q.push_back(mo_q.pop_front());
        end
        if (o_push && !o_ovf) begin
            mo_q.push_back(o_data);
        end
        if (i_pop && mi_q.size() != 0) begin
            exp_mbxi_q.push_back(mi_q.pop_front());
        end
        if (i_wr && !i_ovf) begin
            mi_q.push_back(i_data);
        end
`ifdef URV_DBG_MBX_OVF_EN
        ovf_i = i_ovf || (ovf_i && !(s_we && s_wdata[4]));
        ovf_o = o_ovf || (ovf_o && !(s_we && s_wdata[5]));
`endif
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    // Monitor: compares status every cycle and every word handed out by a pop.
    always @(negedge clk_i) begin
        if (mon_en) begin
            checkOutput("status", csr_status_o, exp_status);
            checkOutput("mbxi_full", 32'(dbg_mbxi_full_o), 32'(exp_status[2]));
            checkOutput("mbxo_avail", 32'(dbg_mbxo_full_o), 32'(exp_status[1]));
            if (dbg_mbxo_read_i && dbg_mbxo_full_o) begin
                if (exp_mbxo_q.size() == 0) begin
                    checkOutput("mbxo_unexpected_pop", 32'd1, 32'd0);
                end else begin
                    checkOutput("mbxo_data", dbg_mbxo_data_o, exp_mbxo_q.pop_front());
                end
            end
            if (csr_mbxi_pop_i && csr_status_o[0]) begin
                if (exp_mbxi_q.size() == 0) begin
                    checkOutput("mbxi_unexpected_pop", 32'd1, 32'd0);
                end else begin
                    checkOutput("mbxi_data", csr_mbxi_data_o, exp_mbxi_q.pop_front());
                end
            end
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_status"}, csr_status_o, 32'h0);
        checkOutput({tag, "_mbxi_full"}, 32'(dbg_mbxi_full_o), 32'h0);
        checkOutput({tag, "_mbxo_avail"}, 32'(dbg_mbxo_full_o), 32'h0);
        checkOutput({tag, "_mbxo_head"}, dbg_mbxo_data_o, 32'h0);
        checkOutput({tag, "_mbxi_head"}, csr_mbxi_data_o, 32'h0);
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        int               push_pct;
        int               pop_pct;

        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checkResetState("reset");
        @(negedge clk_i);
        rst_i = 1'b0;

        // MBXO ordering and count.
        applyStimulus(1'b1, 32'h11, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 32'h22, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 32'h33, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        idle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        end
        idle();

        // MBXI fill beyond capacity, then overflow set vs W1C clear in the same cycle.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0, '0);
        end
        idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hA5, 1'b0, 1'b1, 32'h10);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 32'h10);
        idle();

        // Push and pop together on a full MBXI.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'hA4, 1'b1, 1'b0, '0);
        idle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        end
        // Pop from empty plus push into empty in one cycle.
        applyStimulus(1'b1, 32'h77, 1'b1, 1'b1, 32'h88, 1'b1, 1'b0, '0);
        idle();

        // Pointer wrap with a standing entry.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), 1'b1, 1'b1, 32'h200 + 32'(i), 1'b1, 1'b0, '0);
        end
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        idle();

        // Random traffic; phases bias towards full and towards empty.
        for (int i = 0; i < 600; i++) begin
            push_pct = ((i / 50) % 2 == 0) ? 70 : 30;
            pop_pct  = 100 - push_pct;
            d = $urandom;
            applyStimulus($urandom_range(0, 99) < push_pct, d,
                          $urandom_range(0, 99) < pop_pct,
                          $urandom_range(0, 99) < push_pct, $urandom,
                          $urandom_range(0, 99) < pop_pct,
                          $urandom_range(0, 9) == 0, $urandom);
        end
        idle();

        // Reset mid-stream with two words waiting in MBXO.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h30);
        end
        applyStimulus(1'b1, 32'hC1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 32'hC2, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        idle();
        @(posedge clk_i);
        #2;
        mon_en = 1'b0;
        rst_i  = 1'b1;
        #1;
        checkResetState("midreset");
        mi_q.delete();
        mo_q.delete();
        ovf_i = 1'b0;
        ovf_o = 1'b0;
        checkOutput("midreset_pending_o", 32'(exp_mbxo_q.size()), 32'h0);
        checkOutput("midreset_pending_i", 32'(exp_mbxi_q.size()), 32'h0);
        exp_mbxo_q.delete();
        exp_mbxi_q.delete();
        @(negedge clk_i);
        rst_i = 1'b0;

        applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        idle();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        idle();
        @(posedge clk_i);
        #1;
        mon_en = 1'b0;

        checkOutput("final_pending_o", 32'(exp_mbxo_q.size()), 32'h0);
        checkOutput("final_pending_i", 32'(exp_mbxi_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
